bit_serial_sub_ctrl: RTL and testbench

BIT_SERIAL_SUB_CTRL -- requirements
Module: bit_serial_sub_ctrl

---
 rtl/bit_serial_sub_ctrl.sv | 116 +++++++++++
 tb/tb_bit_serial_sub_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bit_serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell time-shared over WIDTH bits, LSB first.
// Each operation takes WIDTH RUN cycles, then one DONE cycle that can accept the next start.
module bit_serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned      CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;

    logic             cell_x, cell_y, cell_d, cell_bout;
    logic [WIDTH-1:0] res_next;

    // The single shared full-subtractor cell
    always_comb begin
        cell_x    = a_sh_q[0];
        cell_y    = b_sh_q[0];
        cell_d    = cell_x ^ cell_y ^ br_q;
        cell_bout = (~cell_x & cell_y) | (~cell_x & br_q) | (cell_y & br_q);
        res_next  = {cell_d, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        br_d         = br_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_next;
                br_d   = cell_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                // Visible result only changes on the edge that completes the last bit
                if (cnt_q == LAST) begin
                    state_d      = DONE;
                    diff_d       = res_next;
                    borrow_out_d = cell_bout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            br_q         <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            br_q         <= br_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    always_comb begin
        busy       = (state_q == RUN);
        done       = (state_q == DONE);
        diff       = diff_q;
        borrow_out = borrow_out_q;
    end

endmodule

// File: tb/tb_bit_serial_sub_ctrl.sv
// Directed bench for bit_serial_sub_ctrl (WIDTH=8): latency, results, ignored starts, reset abort, back-to-back.
module tb_bit_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       busy, done, borrow_out;
    logic [7:0] diff;

    int n_cmp = 0;
    int n_err = 0;

    bit_serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation from an idle state; operands are scrambled during RUN.
    // glitch >= 0 issues a stray start (a=0x00, b=0xFF) in that RUN cycle.
    task automatic run_op(input logic [7:0] a_v, input logic [7:0] b_v, input logic bin_v,
                          input logic [7:0] exp_d, input logic exp_b,
                          input logic [7:0] prev_d, input logic prev_b, input int glitch);
        @(negedge clk);
        start = 1'b1; a = a_v; b = b_v; bin = bin_v;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("run_busy", busy, 1'b1);
            check_eq("run_done", done, 1'b0);
            check_eq("run_diff_hold", diff, prev_d);
            check_eq("run_bout_hold", borrow_out, prev_b);
            start = (i == glitch);
            if (i == glitch) begin
                a = 8'h00; b = 8'hFF; bin = 1'b0;
            end else begin
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        check_eq("done_pulse", done, 1'b1);
        check_eq("done_busy", busy, 1'b0);
        check_eq("diff", diff, exp_d);
        check_eq("borrow_out", borrow_out, exp_b);
        @(negedge clk);
        check_eq("idle_done", done, 1'b0);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_diff_hold", diff, exp_d);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_diff", diff, 8'h00);
        check_eq("rst_bout", borrow_out, 1'b0);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check_eq("idle_after_rst", busy, 1'b0);

        run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 8'h00, 1'b0, -1);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 8'h1E, 1'b0, -1);
        run_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, -1);
        run_op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 8'hFF, 1'b1, -1);
        run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 8'hFE, 1'b0, -1);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 8'h00, 1'b1, 2);
        // Stray start must not have queued a second operation
        repeat (10) begin
            @(negedge clk);
            check_eq("no_queued_done", done, 1'b0);
            check_eq("no_queued_busy", busy, 1'b0);
        end
        check_eq("diff_after_glitch", diff, 8'h7F);

        // Reset on the 4th RUN edge aborts the operation
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_abort_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_diff", diff, 8'h00);
        check_eq("abort_bout", borrow_out, 1'b0);
        repeat (10) begin
            @(negedge clk);
            check_eq("abort_no_done", done, 1'b0);
        end
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 8'h00, 1'b0, -1);

        // Back-to-back with start held high: 0x33 - 0x44 - 1 = 0xEE, borrow
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h44; bin = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check_eq("b2b_busy", busy, 1'b1);
                check_eq("b2b_done_low", done, 1'b0);
            end
            @(negedge clk);
            check_eq("b2b_done", done, 1'b1);
            check_eq("b2b_busy_low", busy, 1'b0);
            check_eq("b2b_diff", diff, 8'hEE);
            check_eq("b2b_bout", borrow_out, 1'b1);
        end
        start = 1'b0;
        @(negedge clk);
        check_eq("b2b_end_done", done, 1'b0);
        check_eq("b2b_end_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
